// File: rtl/booth_multiplier_module_if.sv
// Request/operand/result bundle for the radix-2 Booth multiplier.
// The master drives the request and operands; the slave returns the result and status.
interface booth_multiplier_module_if;
   localparam int unsigned OP_W   = 8;
   localparam int unsigned PROD_W = 16;

   logic              start_sig;
   logic [OP_W-1:0]   multiplicand;
   logic [OP_W-1:0]   multiplier;
   logic              done_sig;
   logic [PROD_W-1:0] product;
   logic              busy_sig;

   modport master (
      output start_sig, multiplicand, multiplier,
      input  done_sig, product, busy_sig
   );

   modport slave (
      input  start_sig, multiplicand, multiplier,
      output done_sig, product, busy_sig
   );
endinterface

// File: rtl/booth_multiplier_module.sv
// Sequential 8x8 signed radix-2 Booth multiplier: one Booth step per cycle,
// followed by a one-cycle done pulse and a wait for the request to be released.
module booth_multiplier_module (
   input  logic                        clk,
   input  logic                        rst_n,
   booth_multiplier_module_if.slave    bus
);
   localparam int unsigned OP_W   = 8;
   localparam int unsigned EXT_W  = OP_W + 1;
   localparam int unsigned ACC_W  = 2 * EXT_W;
   localparam int unsigned PROD_W = 2 * OP_W;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CALC     = 2'd1,
      DONE     = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [EXT_W-1:0]    m_q, m_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic [PROD_W-1:0]   prod_q, prod_d;
   logic [EXT_W-1:0]    upper;
   logic [EXT_W-1:0]    sum;

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         prod_q  <= prod_d;
      end
   end

   // Next-state and datapath; the 9-bit upper field keeps -128 from overflowing
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      upper   = acc_q[ACC_W-1:OP_W+1];
      sum     = upper;

      case (state_q)
         IDLE: begin
            if (bus.start_sig) begin
               m_d     = {bus.multiplicand[OP_W-1], bus.multiplicand};
               acc_d   = {EXT_W'(0), bus.multiplier, 1'b0};
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            case (acc_q[1:0])
               2'b01:   sum = upper + m_q;
               2'b10:   sum = upper - m_q;
               default: sum = upper;
            endcase
            acc_d = {sum[EXT_W-1], sum, acc_q[OP_W:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (!bus.start_sig) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Result is captured once, on leaving DONE, and held until the next one
      done_d = (state_q == DONE);
      prod_d = (state_q == DONE) ? acc_q[PROD_W:1] : prod_q;
      busy_d = (state_d != IDLE);
   end

   assign bus.done_sig = done_q;
   assign bus.busy_sig = busy_q;
   assign bus.product  = prod_q;

endmodule

// File: tb/tb_booth_multiplier_module.sv
// Self-checking bench: directed scenarios plus random signed operand pairs
// compared against a plain signed multiply.
module tb_booth_multiplier_module;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   booth_multiplier_module_if bus ();

   booth_multiplier_module dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      return 16'(sa * sb);
   endfunction

   // Full request/done handshake for one operation
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input bit drop_early, input bit check_lat);
      logic [15:0] exp;
      int  n;
      bit  seen;
      exp = ref_mul(a, b);
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.start_sig    = 1'b1;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) check_eq("busy_after_start", 32'(bus.busy_sig), 32'd1);
         if (n == 4 && drop_early) bus.start_sig = 1'b0;
         if (bus.done_sig) seen = 1'b1;
      end
      check_eq("done_seen", 32'(seen), 32'd1);
      if (check_lat) check_eq("done_latency", 32'(n - 1), 32'd9);
      check_eq("product", 32'(bus.product), 32'(exp));
      bus.start_sig    = 1'b0;
      bus.multiplicand = 8'($urandom);
      bus.multiplier   = 8'($urandom);
      @(posedge clk); #1;
      check_eq("done_one_cycle", 32'(bus.done_sig), 32'd0);
      check_eq("product_held", 32'(bus.product), 32'(exp));
   endtask

   initial begin
      int pulses;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.start_sig    = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      #1;
      check_eq("reset_done", 32'(bus.done_sig), 32'd0);
      check_eq("reset_busy", 32'(bus.busy_sig), 32'd0);
      check_eq("reset_product", 32'(bus.product), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'd10, 8'd2, 1'b0, 1'b1);
      check_eq("10x2_const", 32'(bus.product), 32'h0014);
      run_op(8'd2, 8'd10, 1'b0, 1'b1);
      check_eq("2x10_const", 32'(bus.product), 32'h0014);
      run_op(8'd11, 8'hFB, 1'b0, 1'b1);
      check_eq("11xm5_const", 32'(bus.product), 32'hFFC9);
      run_op(8'hFB, 8'hF5, 1'b0, 1'b0);
      check_eq("m5xm11_const", 32'(bus.product), 32'h0037);
      run_op(8'h80, 8'h80, 1'b0, 1'b0);
      check_eq("m128xm128", 32'(bus.product), 32'h4000);
      run_op(8'h80, 8'h7F, 1'b0, 1'b0);
      check_eq("m128x127", 32'(bus.product), 32'hC080);
      run_op(8'h00, 8'hFF, 1'b0, 1'b0);
      check_eq("0xm1", 32'(bus.product), 32'h0000);

      // start_sig held for 30 cycles must give exactly one pulse
      bus.multiplicand = 8'd7;
      bus.multiplier   = 8'hFA;
      bus.start_sig    = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.done_sig) pulses++;
      end
      check_eq("held_start_pulses", 32'(pulses), 32'd1);
      check_eq("held_start_product", 32'(bus.product), 32'hFFD6);
      check_eq("held_start_busy", 32'(bus.busy_sig), 32'd1);
      bus.start_sig = 1'b0;
      repeat (3) @(posedge clk); #1;
      check_eq("released_busy", 32'(bus.busy_sig), 32'd0);
      check_eq("released_product", 32'(bus.product), 32'hFFD6);

      // Reset in the middle of CALC abandons the operation
      bus.multiplicand = 8'd10;
      bus.multiplier   = 8'd2;
      bus.start_sig    = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("midreset_done", 32'(bus.done_sig), 32'd0);
      check_eq("midreset_busy", 32'(bus.busy_sig), 32'd0);
      check_eq("midreset_product", 32'(bus.product), 32'd0);
      bus.start_sig = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.done_sig) pulses++;
      end
      check_eq("midreset_no_pulse", 32'(pulses), 32'd0);
      run_op(8'd3, 8'd3, 1'b0, 1'b1);
      check_eq("after_reset_3x3", 32'(bus.product), 32'h0009);

      // Operand changes during CALC are ignored
      bus.multiplicand = 8'd10;
      bus.multiplier   = 8'd2;
      bus.start_sig    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.multiplicand = 8'd1;
      bus.multiplier   = 8'd1;
      pulses = 0;
      for (int i = 0; i < 12 && pulses == 0; i++) begin
         @(posedge clk); #1;
         if (bus.done_sig) pulses++;
      end
      check_eq("opchange_done", 32'(pulses), 32'd1);
      check_eq("opchange_product", 32'(bus.product), 32'h0014);
      bus.start_sig = 1'b0;
      @(posedge clk); #1;

      // Random back-to-back operations, some with start_sig dropped mid-CALC
      for (int k = 0; k < 1000; k++) begin
         run_op(8'($urandom), 8'($urandom), bit'($urandom_range(0, 3) == 0), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
